// File: rtl/uart_tx_buffered_if.sv
// rtl/uart_tx_buffered_if.sv - byte send handshake between producer and buffered UART transmitter
interface uart_tx_buffered_if;
  logic       valid_send;
  logic [7:0] data_send;
  logic       ready_send;

  modport master (output valid_send, output data_send, input ready_send);
  modport slave  (input valid_send, input data_send, output ready_send);
endinterface

// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - buffered 8N1 UART transmitter, FIFO-fed, LSB-first
module uart_tx_buffered #(
  parameter int CLK_PER_HALF_BIT = 868,
  parameter int FIFO_AW          = 4
) (
  input  logic                clk,
  input  logic                rstn,
  uart_tx_buffered_if.slave   send,
  output logic                UART_TX,
  output logic                busy,
  output logic [FIFO_AW:0]    fifo_count
);
  localparam int BIT_CYC = 2 * CLK_PER_HALF_BIT;
  localparam int CW      = $clog2(BIT_CYC);
  localparam int DEPTH   = 1 << FIFO_AW;
  localparam logic [CW-1:0]    BAUD_LAST = CW'(BIT_CYC - 1);
  localparam logic [FIFO_AW:0] FULL      = {1'b1, {FIFO_AW{1'b0}}};

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state, state_n;
  logic [CW-1:0]       baud, baud_n;
  logic [2:0]          bit_idx, bit_idx_n;
  logic [7:0]          shift, shift_n;
  logic                tx, tx_n;
  logic                baud_done;
  logic                push, pop;
  logic                not_empty;
  logic [7:0]          mem [DEPTH];
  logic [FIFO_AW-1:0]  wr_ptr, rd_ptr;
  logic [FIFO_AW:0]    count;

  // ready depends only on the registered count, never on valid_send
  assign send.ready_send = (count != FULL);
  assign push            = send.valid_send & send.ready_send;
  assign not_empty       = (count != '0);
  assign baud_done       = (baud == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= send.data_send;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_n;
      baud    <= baud_n;
      bit_idx <= bit_idx_n;
      shift   <= shift_n;
      tx      <= tx_n;
    end
  end

  always_comb begin
    state_n   = state;
    baud_n    = baud;
    bit_idx_n = bit_idx;
    shift_n   = shift;
    tx_n      = tx;
    pop       = 1'b0;
    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        baud_n = '0;
        if (not_empty) begin
          pop     = 1'b1;
          shift_n = mem[rd_ptr];
          tx_n    = 1'b0;
          state_n = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_n    = '0;
          bit_idx_n = '0;
          tx_n      = shift[0];
          state_n   = DATA;
        end else begin
          baud_n = baud + CW'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            // line always carries shift[0]; the next bit is shift[1]
            bit_idx_n = bit_idx + 3'd1;
            shift_n   = {1'b0, shift[7:1]};
            tx_n      = shift[1];
          end
        end else begin
          baud_n = baud + CW'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_n = '0;
          if (not_empty) begin
            pop     = 1'b1;
            shift_n = mem[rd_ptr];
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            tx_n    = 1'b1;
            state_n = IDLE;
          end
        end else begin
          baud_n = baud + CW'(1);
        end
      end
      default: begin
        tx_n    = 1'b1;
        baud_n  = '0;
        state_n = IDLE;
      end
    endcase
  end

  assign UART_TX    = tx;
  assign busy       = (state != IDLE) | not_empty;
  assign fifo_count = count;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb/tb_uart_tx_buffered.sv - directed self-checking bench for uart_tx_buffered
module tb_uart_tx_buffered;
  localparam int HB  = 4;
  localparam int AW  = 2;
  localparam int BIT = 2 * HB;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          uart_tx;
  logic          busy;
  logic [AW:0]   fifo_count;

  uart_tx_buffered_if send_if ();

  uart_tx_buffered #(.CLK_PER_HALF_BIT(HB), .FIFO_AW(AW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .send       (send_if),
    .UART_TX    (uart_tx),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // independent line decoder: samples each bit at its centre
  logic [7:0] rx_q[$];
  int         rx_start[$];
  logic [7:0] exp_q[$];
  int         frame_err = 0;
  bit         mon_active = 1'b0;
  int         mon_cnt = 0;
  int         mon_bit = 0;
  logic [7:0] mon_byte = 8'h00;

  always @(negedge clk) begin
    if (!rstn) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (uart_tx === 1'b0) begin
        mon_active = 1'b1;
        mon_cnt    = 0;
        rx_start.push_back(cyc);
      end
    end else begin
      mon_cnt++;
      if (mon_cnt % BIT == BIT / 2) begin
        mon_bit = mon_cnt / BIT;
        if (mon_bit == 0) begin
          if (uart_tx !== 1'b0) frame_err++;
        end else if (mon_bit <= 8) begin
          mon_byte[mon_bit-1] = uart_tx;
        end else begin
          if (uart_tx !== 1'b1) frame_err++;
          rx_q.push_back(mon_byte);
          mon_active = 1'b0;
        end
      end
    end
  end

  task automatic check_rx(input string tag);
    check_eq({tag, " frames"}, 32'(rx_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      check_eq($sformatf("%s byte%0d", tag, k),
               (k < rx_q.size()) ? 32'(rx_q[k]) : 32'hDEAD_BEEF, 32'(exp_q[k]));
    end
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n = 0;
    while (busy !== 1'b0 && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  logic [9:0] frame;
  logic [7:0] samp;
  logic [7:0] t4_bytes [6] = '{8'h11, 8'h22, 8'h3C, 8'h4B, 8'h5A, 8'h69};
  bit         bad_tx, bad_rdy, bad_busy, bad_cnt;
  bit         acc, saw_full, ready_bad;
  int         idx, n, max_cnt, e0;

  initial begin
    send_if.valid_send = 1'b0;
    send_if.data_send  = 8'h00;
    repeat (3) @(negedge clk);

    // 1: reset values, then 100 idle cycles
    check_eq("rst tx", 32'(uart_tx), 32'd1);
    check_eq("rst ready", 32'(send_if.ready_send), 32'd1);
    check_eq("rst busy", 32'(busy), 32'd0);
    check_eq("rst count", 32'(fifo_count), 32'd0);
    rstn = 1'b1;
    {bad_tx, bad_rdy, bad_busy, bad_cnt} = 4'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1) bad_tx = 1'b1;
      if (send_if.ready_send !== 1'b1) bad_rdy = 1'b1;
      if (busy !== 1'b0) bad_busy = 1'b1;
      if (fifo_count !== '0) bad_cnt = 1'b1;
    end
    check_eq("idle tx deviation", 32'(bad_tx), 32'd0);
    check_eq("idle ready deviation", 32'(bad_rdy), 32'd0);
    check_eq("idle busy deviation", 32'(bad_busy), 32'd0);
    check_eq("idle count deviation", 32'(bad_cnt), 32'd0);

    // 2: single 0xA5 frame, every cycle checked
    send_if.valid_send = 1'b1;
    send_if.data_send  = 8'hA5;
    check_eq("t2 ready", 32'(send_if.ready_send), 32'd1);
    @(negedge clk);
    send_if.valid_send = 1'b0;
    check_eq("t2 count pushed", 32'(fifo_count), 32'd1);
    check_eq("t2 busy pushed", 32'(busy), 32'd1);
    frame = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 10; i++) begin
      for (int j = 0; j < BIT; j++) begin
        @(negedge clk);
        samp[j] = uart_tx;
        if (i == 0 && j == 0) check_eq("t2 count after pop", 32'(fifo_count), 32'd0);
      end
      check_eq($sformatf("t2 bit%0d", i), 32'(samp), frame[i] ? 32'hFF : 32'h00);
    end
    check_eq("t2 busy E+80", 32'(busy), 32'd1);
    @(negedge clk);
    check_eq("t2 busy E+81", 32'(busy), 32'd0);
    check_eq("t2 tx E+81", 32'(uart_tx), 32'd1);
    exp_q.delete();
    exp_q.push_back(8'hA5);
    check_rx("t2");

    // 3: three bytes on consecutive edges, frames back to back
    rx_q.delete();
    rx_start.delete();
    send_if.valid_send = 1'b1;
    send_if.data_send  = 8'h00;
    @(negedge clk);
    send_if.data_send  = 8'hFF;
    @(negedge clk);
    send_if.data_send  = 8'h55;
    @(negedge clk);
    send_if.valid_send = 1'b0;
    wait_idle("t3", 400);
    exp_q.delete();
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'h55);
    check_rx("t3");
    check_eq("t3 gap01", (rx_start.size() >= 2) ? 32'(rx_start[1] - rx_start[0]) : 32'hDEAD_BEEF, 32'd80);
    check_eq("t3 gap12", (rx_start.size() >= 3) ? 32'(rx_start[2] - rx_start[1]) : 32'hDEAD_BEEF, 32'd80);

    // 4: valid held high through six bytes; FIFO fills, ready drops at 4
    rx_q.delete();
    idx = 0; n = 0; max_cnt = 0; saw_full = 1'b0; ready_bad = 1'b0;
    while (idx < 6 && n < 400) begin
      send_if.valid_send = 1'b1;
      send_if.data_send  = t4_bytes[idx];
      acc = send_if.ready_send;
      if (fifo_count == 3'd4) begin
        saw_full = 1'b1;
        if (send_if.ready_send !== 1'b0) ready_bad = 1'b1;
      end else if (send_if.ready_send !== 1'b1) begin
        ready_bad = 1'b1;
      end
      if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
      @(negedge clk);
      n++;
      if (acc) idx++;
    end
    send_if.valid_send = 1'b0;
    check_eq("t4 accepted", 32'(idx), 32'd6);
    check_eq("t4 max count", 32'(max_cnt), 32'd4);
    check_eq("t4 saw full", 32'(saw_full), 32'd1);
    check_eq("t4 ready vs full", 32'(ready_bad), 32'd0);
    wait_idle("t4", 800);
    exp_q.delete();
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h4B);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h69);
    check_rx("t4");

    // 5: push lands on the same edge as the STOP-end pop
    rx_q.delete();
    send_if.valid_send = 1'b1;
    send_if.data_send  = 8'h81;
    @(negedge clk);
    e0 = cyc;
    send_if.data_send  = 8'h42;
    @(negedge clk);
    send_if.data_send  = 8'hC3;
    @(negedge clk);
    send_if.data_send  = 8'h24;
    @(negedge clk);
    send_if.valid_send = 1'b0;
    check_eq("t5 count filled", 32'(fifo_count), 32'd3);
    while (cyc < e0 + 80) @(negedge clk);
    send_if.valid_send = 1'b1;
    send_if.data_send  = 8'hE7;
    check_eq("t5 ready pre", 32'(send_if.ready_send), 32'd1);
    check_eq("t5 tx stop", 32'(uart_tx), 32'd1);
    @(negedge clk);
    send_if.valid_send = 1'b0;
    check_eq("t5 count push+pop", 32'(fifo_count), 32'd3);
    check_eq("t5 next start", 32'(uart_tx), 32'd0);
    wait_idle("t5", 600);
    exp_q.delete();
    exp_q.push_back(8'h81);
    exp_q.push_back(8'h42);
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h24);
    exp_q.push_back(8'hE7);
    check_rx("t5");

    // 6: reset in the middle of data bit 3 of 0x96
    rx_q.delete();
    send_if.valid_send = 1'b1;
    send_if.data_send  = 8'h96;
    @(negedge clk);
    e0 = cyc;
    send_if.data_send  = 8'h0F;
    @(negedge clk);
    send_if.data_send  = 8'hF0;
    @(negedge clk);
    send_if.valid_send = 1'b0;
    while (cyc < e0 + 36) @(negedge clk);
    check_eq("t6 tx bit3", 32'(uart_tx), 32'd0);
    check_eq("t6 count pre", 32'(fifo_count), 32'd2);
    #1;
    rstn = 1'b0;
    #1;
    check_eq("t6 tx in reset", 32'(uart_tx), 32'd1);
    check_eq("t6 count in reset", 32'(fifo_count), 32'd0);
    check_eq("t6 ready in reset", 32'(send_if.ready_send), 32'd1);
    check_eq("t6 busy in reset", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    rx_q.delete();
    send_if.valid_send = 1'b1;
    send_if.data_send  = 8'h3C;
    @(negedge clk);
    send_if.valid_send = 1'b0;
    wait_idle("t6", 200);
    exp_q.delete();
    exp_q.push_back(8'h3C);
    check_rx("t6");

    check_eq("framing errors", 32'(frame_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
